// File: rtl/motor_cmd_regfile.sv
// SPI command decoder and register file for N_CH stepper channels.
// Optional command watchdog is built when MOTOR_WDOG_EN is defined.
module motor_cmd_regfile #(
    parameter int N_CH     = 6,
    parameter int DIV_W    = 16,
    parameter int POS_W    = 32,
    parameter int WDOG_CYC = 1000000
) (
    input  logic                    CLK,
    input  logic                    reset_n,
    input  logic                    word_recvd,
    input  logic [15:0]             recv_data,
    output logic [15:0]             reply_data,
    input  logic [N_CH*POS_W-1:0]   cur_pos,
    output logic [N_CH*DIV_W-1:0]   divider,
    output logic [N_CH-1:0]         move_dir,
    output logic [N_CH-1:0]         step_ena,
    output logic [N_CH-1:0]         pos_reset,
    output logic [3:0]              sel_ch,
    output logic                    wdog_trip
);

    localparam logic [15:0] REPLY_OK    = 16'h4F4B;
    localparam logic [15:0] REPLY_BAD   = 16'hEEEE;
    localparam logic [31:0] N_CH_U      = 32'(N_CH);
    localparam logic [12:0] SHADOW_MASK = 13'((1 << (DIV_W - 13)) - 1);

    typedef enum logic [2:0] {
        OP_SEL  = 3'd0,
        OP_DIR  = 3'd1,
        OP_DIVL = 3'd2,
        OP_ENA  = 3'd3,
        OP_POSH = 3'd4,
        OP_DIVH = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } opcode_e;

    logic                   word_recvd_q, word_recvd_d;
    logic [15:0]            reply_q, reply_d;
    logic [3:0]             sel_q, sel_d;
    logic [31:0]            snap_q, snap_d;
    logic [12:0]            shadow_q, shadow_d;
    logic [N_CH*DIV_W-1:0]  div_q, div_d;
    logic [N_CH-1:0]        dir_q, dir_d;
    logic [N_CH-1:0]        ena_q, ena_d;
    logic [N_CH-1:0]        pr_q, pr_d;

    logic                   cmd_edge;
    opcode_e                opcode;
    logic [3:0]             ch_new;
    logic                   ch_ok;
    logic [N_CH-1:0]        new_oh;
    logic [N_CH-1:0]        sel_oh;
    logic signed [POS_W-1:0] pos_sel;
    logic [31:0]            pos_ext;
    logic [DIV_W-1:0]       div_word;

`ifdef MOTOR_WDOG_EN
    localparam int CNT_W = $clog2(WDOG_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(WDOG_CYC - 1);
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   trip_q, trip_d;
`endif

    always_comb begin
        word_recvd_d = word_recvd;
        reply_d      = reply_q;
        sel_d        = sel_q;
        snap_d       = snap_q;
        shadow_d     = shadow_q;
        div_d        = div_q;
        dir_d        = dir_q;
        ena_d        = ena_q;
        pr_d         = '0;
`ifdef MOTOR_WDOG_EN
        cnt_d        = cnt_q;
        trip_d       = trip_q;
`endif

        cmd_edge = word_recvd & ~word_recvd_q;
        opcode   = opcode_e'(recv_data[15:13]);
        ch_new   = recv_data[3:0];
        ch_ok    = {28'd0, ch_new} < N_CH_U;
        new_oh   = '0;
        sel_oh   = '0;
        pos_sel  = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            new_oh[i] = ({28'd0, ch_new} == i);
            sel_oh[i] = ({28'd0, sel_q} == i);
            if (new_oh[i]) pos_sel = cur_pos[i*POS_W +: POS_W];
        end
        pos_ext  = 32'(pos_sel);
        // Upper shadow bits are held at zero, so truncation yields exactly DIV_W bits.
        div_word = DIV_W'({shadow_q, recv_data[12:0]});

        if (cmd_edge) begin
            case (opcode)
                OP_SEL: begin
                    if (ch_ok) begin
                        sel_d   = ch_new;
                        snap_d  = pos_ext;
                        reply_d = pos_ext[15:0];
                        if (recv_data[4]) pr_d = new_oh;
                    end else begin
                        reply_d = REPLY_BAD;
                    end
                end
                OP_DIR: begin
                    dir_d   = (dir_q & ~sel_oh) | (sel_oh & {N_CH{recv_data[0]}});
                    reply_d = REPLY_OK;
                end
                OP_DIVL: begin
                    for (int unsigned i = 0; i < N_CH; i++) begin
                        if (sel_oh[i]) div_d[i*DIV_W +: DIV_W] = div_word;
                    end
                    reply_d = REPLY_OK;
                end
                OP_ENA: begin
                    if (recv_data[1]) ena_d = {N_CH{recv_data[0]}};
                    else ena_d = (ena_q & ~sel_oh) | (sel_oh & {N_CH{recv_data[0]}});
`ifdef MOTOR_WDOG_EN
                    if (recv_data[0]) trip_d = 1'b0;
`endif
                    reply_d = REPLY_OK;
                end
                OP_POSH: reply_d = snap_q[31:16];
                OP_DIVH: begin
                    shadow_d = recv_data[12:0] & SHADOW_MASK;
                    reply_d  = REPLY_OK;
                end
                default: reply_d = '0;
            endcase
        end

`ifdef MOTOR_WDOG_EN
        // Counter saturates at terminal count so enables stay forced off until a command arrives.
        if (cmd_edge) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_TERM) begin
            ena_d  = '0;
            trip_d = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
`endif
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            word_recvd_q <= 1'b1;
            reply_q      <= '0;
            sel_q        <= '0;
            snap_q       <= '0;
            shadow_q     <= '0;
            div_q        <= '0;
            dir_q        <= '0;
            ena_q        <= '0;
            pr_q         <= '0;
        end else begin
            word_recvd_q <= word_recvd_d;
            reply_q      <= reply_d;
            sel_q        <= sel_d;
            snap_q       <= snap_d;
            shadow_q     <= shadow_d;
            div_q        <= div_d;
            dir_q        <= dir_d;
            ena_q        <= ena_d;
            pr_q         <= pr_d;
        end
    end

`ifdef MOTOR_WDOG_EN
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            trip_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            trip_q <= trip_d;
        end
    end

    assign wdog_trip = trip_q;
`else
    assign wdog_trip = 1'b0;
`endif

    assign reply_data = reply_q;
    assign sel_ch     = sel_q;
    assign divider    = div_q;
    assign move_dir   = dir_q;
    assign step_ena   = ena_q;
    assign pos_reset  = pr_q;

endmodule

// File: tb/tb_motor_cmd_regfile.sv
// Scoreboard bench for motor_cmd_regfile: a high-level model predicts the state after each
// command; an independent monitor compares the cycle after every observed command edge.
module tb_motor_cmd_regfile;

    localparam int N  = 6;
    localparam int DW = 20;
    localparam int PW = 24;
    localparam int WC = 100;
`ifdef MOTOR_WDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              reset_n;
    logic              word_recvd;
    logic [15:0]       recv_data;
    logic [15:0]       reply_data;
    logic [N*PW-1:0]   cur_pos;
    logic [N*DW-1:0]   divider;
    logic [N-1:0]      move_dir, step_ena, pos_reset;
    logic [3:0]        sel_ch;
    logic              wdog_trip;

    always #5 CLK = ~CLK;

    motor_cmd_regfile #(.N_CH(N), .DIV_W(DW), .POS_W(PW), .WDOG_CYC(WC)) dut (
        .CLK(CLK), .reset_n(reset_n), .word_recvd(word_recvd), .recv_data(recv_data),
        .reply_data(reply_data), .cur_pos(cur_pos), .divider(divider), .move_dir(move_dir),
        .step_ena(step_ena), .pos_reset(pos_reset), .sel_ch(sel_ch), .wdog_trip(wdog_trip)
    );

    typedef struct {
        logic [15:0]     reply;
        logic [3:0]      sel;
        logic [N*DW-1:0] div;
        logic [N-1:0]    dir;
        logic [N-1:0]    ena;
        logic [N-1:0]    pr;
        logic            trip;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned clk_idx = 0;
    int unsigned last_edge = 0;

    // Reference state
    int unsigned m_sel = 0;
    logic [31:0] m_snap = '0;
    int unsigned m_shadow = 0;
    int unsigned m_div[N] = '{default: 0};
    logic [N-1:0] m_dir = '0;
    logic [N-1:0] m_ena = '0;
    logic        m_trip = 1'b0;

    always @(posedge CLK) begin
        if (!reset_n) clk_idx <= 0;
        else clk_idx <= clk_idx + 1;
    end

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [N*PW-1:0] rnd_pos();
        logic [159:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) r = {r[127:0], 32'($urandom())};
        return r[N*PW-1:0];
    endfunction

    // Predict the state seen after a command decoded on clock index 'target'.
    task automatic model_cmd(input logic [2:0] op, input logic [12:0] d,
                             input logic [N*PW-1:0] pos, input int unsigned target);
        exp_t x;
        longint p;
        int unsigned ch;
        x.pr    = '0;
        x.reply = 16'h4F4B;
        if (WDOG && (target - last_edge > WC)) begin
            m_ena  = '0;
            m_trip = 1'b1;
        end
        case (op)
            3'd0: begin
                ch = int'(d[3:0]);
                if (ch >= N) begin
                    x.reply = 16'hEEEE;
                end else begin
                    m_sel = ch;
                    p = longint'(pos >> (ch * PW));
                    p = p & ((longint'(1) << PW) - 1);
                    if (p >= (longint'(1) << (PW - 1))) p = p - (longint'(1) << PW);
                    m_snap  = p[31:0];
                    x.reply = m_snap[15:0];
                    if (d[4]) x.pr[ch] = 1'b1;
                end
            end
            3'd1: m_dir[m_sel] = d[0];
            3'd2: m_div[m_sel] = ((m_shadow << 13) + int'(d)) % (1 << DW);
            3'd3: begin
                if (d[1]) m_ena = {N{d[0]}};
                else m_ena[m_sel] = d[0];
                if (d[0]) m_trip = 1'b0;
            end
            3'd4: x.reply = m_snap[31:16];
            3'd5: m_shadow = int'(d) % (1 << (DW - 13));
            default: x.reply = 16'h0000;
        endcase
        x.sel  = 4'(m_sel);
        x.dir  = m_dir;
        x.ena  = m_ena;
        x.trip = m_trip;
        x.div  = '0;
        for (int i = 0; i < N; i++) x.div[i*DW +: DW] = DW'(m_div[i]);
        sb.push_back(x);
    endtask

    // Called and returns 2 time units after a rising clock edge.
    task automatic send(input logic [2:0] op, input logic [12:0] d, input logic [N*PW-1:0] pos,
                        input int unsigned gap, input int unsigned hold);
        int unsigned target;
        target = last_edge + gap;
        if (target < clk_idx + 2) target = clk_idx + 2;
        while (clk_idx + 1 < target) begin
            @(posedge CLK); #2;
        end
        cur_pos    = pos;
        recv_data  = {op, d};
        word_recvd = 1'b1;
        model_cmd(op, d, pos, target);
        last_edge = target;
        @(posedge CLK); #2;
        recv_data = 16'($urandom());
        for (int unsigned k = 1; k < hold; k++) begin
            @(posedge CLK); #2;
        end
        word_recvd = 1'b0;
    endtask

    // Monitor: detects command edges on the bus and checks the following cycle.
    initial begin : monitor
        logic        prev;
        bit          e;
        logic [15:0] last_reply;
        exp_t        x;
        prev = 1'b1;
        last_reply = '0;
        forever begin
            @(posedge CLK);
            e = reset_n && word_recvd && !prev;
            prev = reset_n ? word_recvd : 1'b1;
            @(negedge CLK);
            if (reset_n) begin
                if (e) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 160'(1), 160'(0));
                    end else begin
                        x = sb.pop_front();
                        chk("reply", 160'(reply_data), 160'(x.reply));
                        chk("sel_ch", 160'(sel_ch), 160'(x.sel));
                        chk("divider", 160'(divider), 160'(x.div));
                        chk("move_dir", 160'(move_dir), 160'(x.dir));
                        chk("step_ena", 160'(step_ena), 160'(x.ena));
                        chk("pos_reset", 160'(pos_reset), 160'(x.pr));
                        chk("wdog_trip", 160'(wdog_trip), 160'(x.trip));
                        last_reply = x.reply;
                    end
                end else begin
                    chk("pos_reset_idle", 160'(pos_reset), 160'(0));
                    chk("reply_hold", 160'(reply_data), 160'(last_reply));
                end
            end
        end
    end

    initial begin : timeout
        #5000000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "simulation time limit");
    end

    initial begin : stim
        logic [N*PW-1:0] pos;
        logic [2:0]      op;
        int unsigned     gap;
        reset_n    = 1'b0;
        word_recvd = 1'b1;
        recv_data  = 16'h0012;
        cur_pos    = rnd_pos();
        repeat (3) @(posedge CLK);
        #2 reset_n = 1'b1;
        // Level held high across reset release must not decode.
        repeat (3) begin @(posedge CLK); #2; end
        chk("rst_sel_ch", 160'(sel_ch), 160'(0));
        chk("rst_divider", 160'(divider), 160'(0));
        chk("rst_move_dir", 160'(move_dir), 160'(0));
        chk("rst_step_ena", 160'(step_ena), 160'(0));
        chk("rst_wdog_trip", 160'(wdog_trip), 160'(0));
        chk("rst_reply", 160'(reply_data), 160'(0));
        word_recvd = 1'b0;

        pos = rnd_pos();
        pos[2*PW +: PW] = 24'h0AAAAB;
        send(3'd0, 13'h0012, pos, 8, 1);
        pos[2*PW +: PW] = 24'h7B1234;
        send(3'd4, 13'h0000, pos, 6, 2);

        pos[0 +: PW] = 24'hFFFFFB;
        send(3'd0, 13'h0000, pos, 6, 1);
        send(3'd4, 13'h0000, rnd_pos(), 6, 3);

        send(3'd5, 13'h0005, rnd_pos(), 6, 1);
        send(3'd2, 13'h0123, rnd_pos(), 6, 1);

        send(3'd0, 13'h000F, rnd_pos(), 6, 1);
        send(3'd3, 13'h0003, rnd_pos(), 6, 1);

        send(3'd1, 13'h0001, rnd_pos(), WC, 2);
        send(3'd1, 13'h0000, rnd_pos(), WC + 1, 1);
        send(3'd3, 13'h0003, rnd_pos(), 6, 1);

        for (int n = 0; n < 300; n++) begin
            op  = 3'($urandom_range(0, 7));
            gap = ($urandom_range(0, 19) == 0) ? $urandom_range(WC - 3, WC + 6)
                                                 : $urandom_range(5, 40);
            send(op, 13'($urandom()), rnd_pos(), gap, $urandom_range(1, 3));
        end

        repeat (5) begin @(posedge CLK); #2; end
        chk("sb_drained", 160'(sb.size()), 160'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
